// File: rtl/core_pkg.sv
// Shared encodings and defaults for the memory stage.
// Holds MemtoReg / Branch encodings, stall states and the data-memory width default.
package core_pkg;

    localparam int DMEM_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,
        MTR_MEM  = 2'b01,
        MTR_LINK = 2'b10,
        MTR_UART = 2'b11
    } mtr_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQZ  = 2'b01,
        BR_J    = 2'b10,
        BR_JR   = 2'b11
    } br_t;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_UART_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_dmem.sv
// Data memory: single-port 32-bit synchronous RAM.
// Read-first: a read and a write to the same word on one edge return the old word.
module dmem
    import core_pkg::*;
#(
    parameter int AW = DMEM_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] rdata_q;

    // Read samples the word before this edge's write lands
    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// EX/MEM register, data-memory access, UART receive stall, branch resolve, MEM/WB register.
// Optional: define STALL_COUNT_EN to add a saturating stall_cycles counter output.
module mem_stage
    import core_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 2,
    parameter int DMEM_WIDTH     = DMEM_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      ex_valid,
    input  logic                      RegWrite,
    input  logic                      MemWrite,
    input  logic                      MemRead,
    input  logic                      UARTtoReg,
    input  logic [1:0]                MemtoReg,
    input  logic [1:0]                Branch,
    input  logic [31:0]               register_data,
    input  logic [31:0]               alu_result,
    input  logic [4:0]                rdist,
    input  logic [25:0]               inst_index,
    input  logic [INST_MEM_WIDTH-1:0] pc1,
    input  logic [INST_MEM_WIDTH-1:0] pc2,
    input  logic                      uart_rx_valid,
    input  logic [7:0]                uart_rx_data,
    output logic                      uart_rx_ready,
    output logic                      stall,
    output logic                      branch_taken,
    output logic [INST_MEM_WIDTH-1:0] branch_target,
    output logic                      wb_RegWrite,
    output logic [4:0]                wb_rdist,
    output logic [31:0]               wb_data
`ifdef STALL_COUNT_EN
   ,output logic [31:0]               stall_cycles
`endif
);

    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic                      mem_write;
        logic                      uart;
        mtr_t                      mtr;
        br_t                       br;
        logic [31:0]               rs_data;
        logic [31:0]               alu;
        logic [4:0]                rdist;
        logic [INST_MEM_WIDTH-1:0] idx;
        logic [INST_MEM_WIDTH-1:0] pc1;
        logic [INST_MEM_WIDTH-1:0] pc2;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rdist;
        logic [31:0] data;
        logic        from_mem;
    } mem_wb_t;

    ex_mem_t m_d, m_q;
    mem_wb_t w_d, w_q;
    state_t  state;

    logic [31:0]           rdata;
    logic [DMEM_WIDTH-1:0] addr;
    logic                  we;
    logic                  unused_ok;

    // Reads are always issued; only the low jump-index bits reach the target
    assign unused_ok = ^{MemRead, inst_index[25:INST_MEM_WIDTH]};

    // Stall state derived from the instruction held in M
    always_comb begin
        state = ST_RUN;
        if (m_q.valid && m_q.uart && !uart_rx_valid) state = ST_UART_WAIT;
    end

    assign stall         = (state == ST_UART_WAIT);
    assign uart_rx_ready = m_q.valid && m_q.uart && uart_rx_valid;

    // M register holds while stalled, otherwise captures the EX outputs
    always_comb begin
        m_d = m_q;
        if (!stall) begin
            m_d.valid     = ex_valid;
            m_d.reg_write = RegWrite;
            m_d.mem_write = MemWrite;
            m_d.uart      = UARTtoReg;
            m_d.mtr       = mtr_t'(MemtoReg);
            m_d.br        = br_t'(Branch);
            m_d.rs_data   = register_data;
            m_d.alu       = alu_result;
            m_d.rdist     = rdist;
            m_d.idx       = inst_index[INST_MEM_WIDTH-1:0];
            m_d.pc1       = pc1;
            m_d.pc2       = pc2;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (!rstn) m_q <= '0;
        else       m_q <= m_d;
    end

    // Branch resolve; gated by stall so it fires once per instruction
    always_comb begin
        branch_taken  = 1'b0;
        branch_target = '0;
        if (m_q.valid && !stall) begin
            unique case (m_q.br)
                BR_NONE: branch_taken = 1'b0;
                BR_EQZ: begin
                    branch_taken  = (m_q.alu == '0);
                    branch_target = m_q.pc2;
                end
                BR_J: begin
                    branch_taken  = 1'b1;
                    branch_target = m_q.idx;
                end
                BR_JR: begin
                    branch_taken  = 1'b1;
                    branch_target = m_q.rs_data[INST_MEM_WIDTH-1:0];
                end
            endcase
        end
    end

    // Upper address bits are dropped so accesses wrap
    assign addr = m_q.alu[DMEM_WIDTH+1:2];
    assign we   = rstn && m_q.valid && m_q.mem_write;

    dmem #(.AW(DMEM_WIDTH)) u_dmem (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (m_q.rs_data),
        .rdata (rdata)
    );

    // Writeback bundle; a bubble while stalled
    always_comb begin
        w_d = '0;
        if (!stall) begin
            w_d.reg_write = m_q.valid && m_q.reg_write;
            w_d.rdist     = m_q.rdist;
            w_d.from_mem  = (m_q.mtr == MTR_MEM);
            unique case (m_q.mtr)
                MTR_ALU:  w_d.data = m_q.alu;
                MTR_MEM:  w_d.data = '0;
                MTR_LINK: w_d.data = 32'(m_q.pc1);
                MTR_UART: w_d.data = {24'h0, uart_rx_data};
            endcase
        end
    end

    // MEM/WB pipeline register; memory words come straight from the RAM flop
    always_ff @(posedge clk) begin
        if (!rstn) w_q <= '0;
        else       w_q <= w_d;
    end

    assign wb_RegWrite = w_q.reg_write;
    assign wb_rdist    = w_q.rdist;
    assign wb_data     = w_q.from_mem ? rdata : w_q.data;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cycles_d, stall_cycles_q;

    // Saturating count of stalled cycles
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (!rstn) stall_cycles_q <= '0;
        else       stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard.
// Define STALL_COUNT_EN to also check stall_cycles.
module tb_mem_stage;

    localparam logic [1:0] M_ALU  = 2'b00;
    localparam logic [1:0] M_MEM  = 2'b01;
    localparam logic [1:0] M_LINK = 2'b10;
    localparam logic [1:0] M_UART = 2'b11;
    localparam logic [1:0] B_NONE = 2'b00;
    localparam logic [1:0] B_EQZ  = 2'b01;
    localparam logic [1:0] B_J    = 2'b10;
    localparam logic [1:0] B_JR   = 2'b11;

    typedef struct {
        logic [4:0]  rdist;
        logic [31:0] data;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ex_valid, RegWrite, MemWrite, MemRead, UARTtoReg;
    logic [1:0]  MemtoReg, Branch;
    logic [31:0] register_data, alu_result;
    logic [4:0]  rdist;
    logic [25:0] inst_index;
    logic [1:0]  pc1, pc2;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_ready, stall, branch_taken;
    logic [1:0]  branch_target;
    logic        wb_RegWrite;
    logic [4:0]  wb_rdist;
    logic [31:0] wb_data;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;
    wb_exp_t exp_q[$];

    mem_stage #(.INST_MEM_WIDTH(2), .DMEM_WIDTH(10)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ex_valid      (ex_valid),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .MemRead       (MemRead),
        .UARTtoReg     (UARTtoReg),
        .MemtoReg      (MemtoReg),
        .Branch        (Branch),
        .register_data (register_data),
        .alu_result    (alu_result),
        .rdist         (rdist),
        .inst_index    (inst_index),
        .pc1           (pc1),
        .pc2           (pc2),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_ready (uart_rx_ready),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .wb_RegWrite   (wb_RegWrite),
        .wb_rdist      (wb_rdist),
        .wb_data       (wb_data)
`ifdef STALL_COUNT_EN
       ,.stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; RegWrite = 0; MemWrite = 0; MemRead = 0; UARTtoReg = 0;
        MemtoReg = M_ALU; Branch = B_NONE; register_data = '0; alu_result = '0;
        rdist = '0; inst_index = '0; pc1 = '0; pc2 = '0;
    endtask

    task automatic drive(input logic rw, mw, mr, u2r,
                         input logic [1:0] mtr, br,
                         input logic [31:0] rd, alu,
                         input logic [4:0] rdst,
                         input logic [25:0] idx,
                         input logic [1:0] p1, p2);
        ex_valid = 1; RegWrite = rw; MemWrite = mw; MemRead = mr; UARTtoReg = u2r;
        MemtoReg = mtr; Branch = br; register_data = rd; alu_result = alu;
        rdist = rdst; inst_index = idx; pc1 = p1; pc2 = p2;
    endtask

    // Scoreboard: every register-file write must match the oldest expectation
    always @(negedge clk) begin
        if (wb_RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                chk("sb_rdist", 32'(wb_rdist), 32'(e.rdist));
                chk("sb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        uart_rx_valid = 0;
        uart_rx_data  = '0;
        rstn = 0;
        step();
        step();
        chk("rst_wb_we", 32'(wb_RegWrite), 32'd0);
        chk("rst_wb_rd", 32'(wb_rdist), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ready", 32'(uart_rx_ready), 32'd0);
        chk("rst_br", 32'(branch_taken), 32'd0);
        chk("rst_tgt", 32'(branch_target), 32'd0);
        rstn = 1;

        // Store then load same address
        drive(0, 1, 0, 0, M_ALU, B_NONE, 32'hDEADBEEF, 32'h10, 5'd0, 26'h0, 2'd0, 2'd0);
        step();
        drive(1, 0, 1, 0, M_MEM, B_NONE, 32'h0, 32'h10, 5'd5, 26'h0, 2'd0, 2'd0);
        exp_q.push_back('{5'd5, 32'hDEADBEEF});
        step();
        idle();
        chk("st_no_wb", 32'(wb_RegWrite), 32'd0);
        step();
        chk("ld_we", 32'(wb_RegWrite), 32'd1);
        chk("ld_rd", 32'(wb_rdist), 32'd5);
        chk("ld_data", wb_data, 32'hDEADBEEF);

        // Read-first when MemWrite and MemRead are both set
        drive(0, 1, 0, 0, M_ALU, B_NONE, 32'h11111111, 32'h20, 5'd0, 26'h0, 2'd0, 2'd0);
        step();
        drive(1, 1, 1, 0, M_MEM, B_NONE, 32'h22222222, 32'h20, 5'd6, 26'h0, 2'd0, 2'd0);
        exp_q.push_back('{5'd6, 32'h11111111});
        step();
        drive(1, 0, 1, 0, M_MEM, B_NONE, 32'h0, 32'h20, 5'd7, 26'h0, 2'd0, 2'd0);
        exp_q.push_back('{5'd7, 32'h22222222});
        step();
        idle();
        chk("rw_old", wb_data, 32'h11111111);
        step();
        chk("rw_new", wb_data, 32'h22222222);

        // UART stall for three cycles
        drive(1, 0, 0, 1, M_UART, B_NONE, 32'h0, 32'h0, 5'd9, 26'h0, 2'd0, 2'd0);
        exp_q.push_back('{5'd9, 32'h000000A5});
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("uw_stall", 32'(stall), 32'd1);
            chk("uw_ready", 32'(uart_rx_ready), 32'd0);
            step();
            chk("uw_bubble", 32'(wb_RegWrite), 32'd0);
        end
        uart_rx_valid = 1;
        uart_rx_data  = 8'hA5;
        #1;
        chk("ux_stall", 32'(stall), 32'd0);
        chk("ux_ready", 32'(uart_rx_ready), 32'd1);
        step();
        chk("ux_we", 32'(wb_RegWrite), 32'd1);
        chk("ux_data", wb_data, 32'h000000A5);
        chk("ux_ready_drop", 32'(uart_rx_ready), 32'd0);
`ifdef STALL_COUNT_EN
        chk("stall_cnt", stall_cycles, 32'd3);
`endif
        uart_rx_valid = 0;

        // UART byte already present: no stall
        uart_rx_valid = 1;
        uart_rx_data  = 8'h3C;
        drive(1, 0, 0, 1, M_UART, B_NONE, 32'h0, 32'h0, 5'd10, 26'h0, 2'd0, 2'd0);
        exp_q.push_back('{5'd10, 32'h0000003C});
        step();
        idle();
        chk("ur_nostall", 32'(stall), 32'd0);
        chk("ur_ready", 32'(uart_rx_ready), 32'd1);
        step();
        uart_rx_valid = 0;
        chk("ur_data", wb_data, 32'h0000003C);

        // Conditional branch on zero
        drive(0, 0, 0, 0, M_ALU, B_EQZ, 32'h0, 32'h0, 5'd0, 26'h0, 2'd0, 2'd2);
        step();
        idle();
        chk("beq_taken", 32'(branch_taken), 32'd1);
        chk("beq_tgt", 32'(branch_target), 32'd2);
        step();
        chk("beq_once", 32'(branch_taken), 32'd0);
        drive(0, 0, 0, 0, M_ALU, B_EQZ, 32'h0, 32'h5, 5'd0, 26'h0, 2'd0, 2'd2);
        step();
        idle();
        chk("bne_nt", 32'(branch_taken), 32'd0);

        // Jumps and link
        drive(0, 0, 0, 0, M_ALU, B_J, 32'h0, 32'h7, 5'd0, 26'h3, 2'd0, 2'd0);
        step();
        chk("j_taken", 32'(branch_taken), 32'd1);
        chk("j_tgt", 32'(branch_target), 32'd3);
        drive(0, 0, 0, 0, M_ALU, B_JR, 32'h1, 32'h7, 5'd0, 26'h0, 2'd0, 2'd0);
        step();
        chk("jr_taken", 32'(branch_taken), 32'd1);
        chk("jr_tgt", 32'(branch_target), 32'd1);
        drive(1, 0, 0, 0, M_LINK, B_NONE, 32'h0, 32'h9, 5'd31, 26'h0, 2'd3, 2'd0);
        exp_q.push_back('{5'd31, 32'h00000003});
        step();
        idle();
        step();
        chk("link_data", wb_data, 32'h00000003);

        // Address wrap: 0x1000 aliases 0x0000
        drive(0, 1, 0, 0, M_ALU, B_NONE, 32'hCAFEF00D, 32'h1000, 5'd0, 26'h0, 2'd0, 2'd0);
        step();
        drive(1, 0, 1, 0, M_MEM, B_NONE, 32'h0, 32'h0, 5'd12, 26'h0, 2'd0, 2'd0);
        exp_q.push_back('{5'd12, 32'hCAFEF00D});
        step();
        idle();
        step();
        chk("wrap_data", wb_data, 32'hCAFEF00D);

        // Reset during UART wait abandons the read
        drive(1, 0, 0, 1, M_UART, B_NONE, 32'h0, 32'h0, 5'd13, 26'h0, 2'd0, 2'd0);
        step();
        idle();
        chk("rw_stall", 32'(stall), 32'd1);
        rstn = 0;
        step();
        rstn = 1;
        chk("rr_stall", 32'(stall), 32'd0);
        chk("rr_we", 32'(wb_RegWrite), 32'd0);
        chk("rr_ready", 32'(uart_rx_ready), 32'd0);
        RegWrite = 1;
        rdist = 5'd14;
        alu_result = 32'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("inv_no_wb", 32'(wb_RegWrite), 32'd0);
        end
        idle();
        step();
        step();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
